// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: run-control state encodings and default prescaler terminal count
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, BREAK = 2'd3} run_state_t;
  localparam logic [26:0] COUNT_MAX_DEFAULT = 27'd1_499_999;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: pace tick every COUNT_MAX+1 cycles, or every cycle in turbo
module tick_prescaler
  import cpu_ctrl_pkg::*;
#(
  parameter logic [26:0] COUNT_MAX = COUNT_MAX_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Turbo,
  output logic Tick
);
  logic [26:0] count;
  // starting at 1 puts the first tick COUNT_MAX cycles after reset release
  always_ff @(posedge Clock)
    count <= Reset ? 27'd1 : (count == COUNT_MAX) ? 27'd0 : count + 27'd1;
  assign Tick = (count == 27'd0) || Turbo;
endmodule

// File: rtl/run_controller.sv
// run_controller: run/step/halt/breakpoint sequencing of CPU instruction execution
module run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter logic [26:0] COUNT_MAX = COUNT_MAX_DEFAULT,
  parameter bit          START_RUN = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Turbo,
  input  logic        RunReq,
  input  logic        StepReq,
  input  logic        HaltReq,
  input  logic        BrkEn,
  input  logic [7:0]  BrkAddr,
  input  logic [7:0]  IP,
  output logic        Go,
  output logic [1:0]  State,
  output logic        BrkHit,
  output logic [15:0] InstrCount
);
  logic       tick, bp, skip;
  run_state_t state, state_nx;
  tick_prescaler #(.COUNT_MAX(COUNT_MAX)) u_prescaler (
    .Clock(Clock),
    .Reset(Reset),
    .Turbo(Turbo),
    .Tick (tick)
  );
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= START_RUN ? RUN : HALT;
      skip       <= 1'b0;
      BrkHit     <= 1'b0;
      InstrCount <= 16'd0;
    end else begin
      state      <= state_nx;
      // leaving BREAK lets the breakpointed instruction execute once before re-arming
      skip       <= (state == BREAK && state_nx != BREAK) ? 1'b1 : Go ? 1'b0 : skip;
      BrkHit     <= state == RUN && state_nx == BREAK;
      InstrCount <= InstrCount + 16'(Go);
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      HALT, BREAK: state_nx = HaltReq ? HALT : RunReq ? RUN : StepReq ? STEP : state;
      RUN:         state_nx = HaltReq ? HALT : (tick && bp) ? BREAK : RUN;
      STEP:        state_nx = (HaltReq || Go) ? HALT : STEP;
      default:     state_nx = HALT;
    endcase
  end
  always_comb begin
    bp    = BrkEn && (IP == BrkAddr) && !skip;
    Go    = !Reset && tick && ((state == RUN && !bp) || state == STEP);
    State = state;
  end
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed vectors with hand-computed expectations for run_controller
module tb_run_controller;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Turbo = 1'b0, RunReq = 1'b0, StepReq = 1'b0, HaltReq = 1'b0, BrkEn = 1'b0;
  logic [7:0]  BrkAddr = 8'h05, IP = 8'h00;
  logic        Go, BrkHit, go_h, brk_hit_h;
  logic [1:0]  State, state_h;
  logic [15:0] InstrCount, instr_count_h;
  int          vectors = 0, miscompares = 0, pc = 1;

  run_controller #(.COUNT_MAX(27'd3), .START_RUN(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Turbo(Turbo), .RunReq(RunReq), .StepReq(StepReq),
    .HaltReq(HaltReq), .BrkEn(BrkEn), .BrkAddr(BrkAddr), .IP(IP), .Go(Go), .State(State),
    .BrkHit(BrkHit), .InstrCount(InstrCount)
  );
  run_controller #(.COUNT_MAX(27'd3), .START_RUN(1'b0)) dut_halt (
    .Clock(Clock), .Reset(Reset), .Turbo(Turbo), .RunReq(RunReq), .StepReq(StepReq),
    .HaltReq(HaltReq), .BrkEn(BrkEn), .BrkAddr(BrkAddr), .IP(IP), .Go(go_h), .State(state_h),
    .BrkHit(brk_hit_h), .InstrCount(instr_count_h)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge; pc mirrors the prescaler count for phase-sensitive vectors
  task automatic step();
    @(posedge Clock);
    pc = Reset ? 1 : (pc == 3) ? 0 : pc + 1;
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_state", State, 32'd1);
    chk("rst_state_halt", state_h, 32'd0);
    chk("rst_go", Go, 32'd0);
    chk("rst_cnt", InstrCount, 32'd0);
    chk("rst_brkhit", BrkHit, 32'd0);
    // scenario 1: paced run after reset
    Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1 chk($sformatf("pace_go%0d", i), Go, (i % 4 == 3) ? 32'd1 : 32'd0);
      step();
    end
    chk("pace_cnt", InstrCount, 32'd3);
    // scenario 2: turbo run into breakpoint at 5
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    Turbo = 1'b1;
    BrkEn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      IP = 8'(i);
      #1 chk($sformatf("run_go_ip%0d", i), Go, 32'd1);
      step();
    end
    IP = 8'h05;
    #1 chk("bp_go", Go, 32'd0);
    step();
    chk("bp_state", State, 32'd3);
    chk("bp_hit", BrkHit, 32'd1);
    chk("bp_cnt", InstrCount, 32'd5);
    chk("bp_go_break", Go, 32'd0);
    step();
    chk("bp_hit_pulse", BrkHit, 32'd0);
    chk("bp_hold", State, 32'd3);
    // scenario 3: resume executes IP 5 once, then breaks on return
    RunReq = 1'b1;
    step();
    RunReq = 1'b0;
    #1 chk("resume_go_ip5", Go, 32'd1);
    step();
    IP = 8'h06;
    #1 chk("resume_go_ip6", Go, 32'd1);
    chk("resume_nohit", BrkHit, 32'd0);
    chk("resume_state", State, 32'd1);
    step();
    IP = 8'h07;
    #1 chk("resume_go_ip7", Go, 32'd1);
    step();
    IP = 8'h05;
    #1 chk("loop_go_ip5", Go, 32'd0);
    step();
    chk("loop_state", State, 32'd3);
    chk("loop_hit", BrkHit, 32'd1);
    chk("loop_cnt", InstrCount, 32'd8);
    // scenario 7: reset during BREAK with a request pending
    Reset = 1'b1;
    RunReq = 1'b1;
    #1 chk("rst_brk_go", Go, 32'd0);
    step();
    RunReq = 1'b0;
    chk("rst_brk_go2", Go, 32'd0);
    Reset = 1'b0;
    IP = 8'h10;
    #1 chk("rst_brk_state", State, 32'd1);
    chk("rst_brk_cnt", InstrCount, 32'd0);
    // scenario 5: halt beats run; current Go stands
    HaltReq = 1'b1;
    RunReq = 1'b1;
    #1 chk("halt_go_kept", Go, 32'd1);
    step();
    HaltReq = 1'b0;
    RunReq = 1'b0;
    #1 chk("halt_state", State, 32'd0);
    chk("halt_go", Go, 32'd0);
    step();
    chk("halt_go2", Go, 32'd0);
    chk("halt_cnt", InstrCount, 32'd1);
    // scenario 4: single step, also across a breakpoint address
    StepReq = 1'b1;
    #1 chk("step_go_halt", Go, 32'd0);
    step();
    StepReq = 1'b0;
    #1 chk("step_state", State, 32'd2);
    chk("step_go", Go, 32'd1);
    step();
    chk("step_back", State, 32'd0);
    chk("step_go_after", Go, 32'd0);
    chk("step_cnt", InstrCount, 32'd2);
    IP = 8'h05;
    StepReq = 1'b1;
    step();
    StepReq = 1'b0;
    #1 chk("stepbp_go", Go, 32'd1);
    step();
    chk("stepbp_state", State, 32'd0);
    chk("stepbp_nohit", BrkHit, 32'd0);
    chk("stepbp_cnt", InstrCount, 32'd3);
    // scenario 6: step cancelled by halt before any tick
    Turbo = 1'b0;
    for (int i = 0; i < 4 && pc != 1; i++) step();
    chk("phase", pc, 32'd1);
    StepReq = 1'b1;
    step();
    StepReq = 1'b0;
    HaltReq = 1'b1;
    #1 chk("cancel_step_state", State, 32'd2);
    chk("cancel_go", Go, 32'd0);
    step();
    HaltReq = 1'b0;
    #1 chk("cancel_state", State, 32'd0);
    chk("cancel_cnt", InstrCount, 32'd3);
    // scenario 8: instruction counter wrap
    Reset = 1'b1;
    Turbo = 1'b1;
    IP = 8'h20;
    step();
    Reset = 1'b0;
    repeat (65535) step();
    chk("wrap_pre", InstrCount, 32'hFFFF);
    chk("wrap_go", Go, 32'd1);
    step();
    chk("wrap_cnt", InstrCount, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 The block SHALL have parameter COUNT_MAX, default 27'd1_499_999, which sets the prescaler terminal count.
REQ-002 The block SHALL have parameter START_RUN, default 1, which selects the post-reset state: 1=RUN, 0=HALT.
REQ-003 The block SHALL have port Clock, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port Turbo, input, 1 bit: synchronised level; when high, a pace tick occurs every cycle.
REQ-006 The block SHALL have port RunReq, input, 1 bit: one-cycle pulse requesting free run.
REQ-007 The block SHALL have port StepReq, input, 1 bit: one-cycle pulse requesting execution of exactly one instruction.
REQ-008 The block SHALL have port HaltReq, input, 1 bit: one-cycle pulse requesting a stop.
REQ-009 The block SHALL have port BrkEn, input, 1 bit: breakpoint enable.
REQ-010 The block SHALL have port BrkAddr, input, 8 bits: breakpoint instruction address.
REQ-011 The block SHALL have port IP, input, 8 bits: current CPU instruction pointer.
REQ-012 The block SHALL have port Go, output, 1 bit: combinational instruction-execute enable to the CPU.
REQ-013 The block SHALL have port State, output, 2 bits: current state encoding.
REQ-014 The block SHALL have port BrkHit, output, 1 bit: registered pulse, high for one cycle when a breakpoint is taken.
REQ-015 The block SHALL have port InstrCount, output, 16 bits: count of Go cycles.

Function
REQ-016 The prescaler SHALL be a 27-bit counter that wraps from COUNT_MAX to 0; tick SHALL be (count==0) OR Turbo.
REQ-017 The state machine SHALL use the states HALT=2'd0, RUN=2'd1, STEP=2'd2 and BREAK=2'd3.
REQ-018 bp SHALL be defined as BrkEn AND (IP==BrkAddr) AND NOT skip.
REQ-019 Go SHALL equal tick AND ((State==RUN AND NOT bp) OR State==STEP); Go SHALL never be high in HALT or BREAK.
REQ-020 In RUN, when tick AND bp, the block SHALL suppress Go, enter BREAK on the next edge and assert BrkHit for one cycle.
REQ-021 In STEP, the first cycle with Go=1 SHALL move the state to HALT; STEP SHALL ignore breakpoints.
REQ-022 In HALT or BREAK, RunReq SHALL move the state to RUN and StepReq SHALL move it to STEP.
REQ-023 In RUN, HaltReq SHALL move the state to HALT.
REQ-024 On leaving BREAK, skip SHALL be set; skip SHALL clear on the next Go cycle, so the breakpointed instruction executes exactly once per resume.
REQ-025 When requests are simultaneous, priority SHALL be HaltReq > RunReq > StepReq; HaltReq in STEP SHALL cancel the pending step, with no Go.
REQ-026 RunReq in RUN and StepReq in RUN or STEP SHALL be ignored.
REQ-027 A request arriving in the same cycle as a Go SHALL take effect on the next edge; the current Go SHALL NOT be retracted.
REQ-028 InstrCount SHALL increment by 1 on every cycle with Go=1 and SHALL wrap from 16'hFFFF to 0.
REQ-029 The breakpoint compare SHALL use the combinational IP value of the current cycle, so back-to-back Turbo Go cycles are checked against each new IP.

Reset
REQ-030 On Reset, State SHALL become RUN if START_RUN=1, else HALT.
REQ-031 On Reset, the prescaler count SHALL become 27'd1, so the first non-turbo tick occurs COUNT_MAX cycles after reset is released.
REQ-032 On Reset, skip, BrkHit and InstrCount SHALL become 0.
REQ-033 While Reset is high, Go SHALL be 0, and all requests SHALL be ignored.
REQ-034 Reset asserted during STEP or BREAK SHALL abandon the step or break with no Go.

Structure
REQ-035 Package cpu_ctrl_pkg SHALL hold the state encodings and the default COUNT_MAX, shared with the CPU top level.
REQ-036 The prescaler SHALL be implemented as one sub-module, tick_prescaler (ports Clock, Reset, Turbo, Tick), parameterised by COUNT_MAX.

Verification (COUNT_MAX=3 unless stated)
REQ-037 Scenario 1: release Reset with START_RUN=1 and Turbo=0 -> first Go 3 cycles after release, then one Go every 4 cycles; InstrCount=3 after the third Go.
REQ-038 Scenario 2: Turbo=1, BrkEn=1, BrkAddr=8'h05, IP incrementing from 0 -> Go for IP 0..4, no Go at IP 5, BrkHit for one cycle, State=BREAK, InstrCount=5.
REQ-039 Scenario 3: from that BREAK, RunReq pulse with IP held at 5 for one Go, then 6 -> exactly one Go at IP 5, continues to IP 6 in RUN with no second BrkHit; with a program loop returning to IP 5, breaks again.
REQ-040 Scenario 4: in HALT, StepReq with Turbo=1 -> exactly one Go, State returns to HALT the next cycle; StepReq while IP==BrkAddr -> one Go, no BrkHit.
REQ-041 Scenario 5: HaltReq and RunReq in the same cycle while in RUN -> State=HALT, no further Go.
REQ-042 Scenario 6: StepReq immediately followed by HaltReq before any tick -> State=HALT with no Go.
REQ-043 Scenario 7: Reset mid-BREAK -> State=RUN, InstrCount=0, Go=0 during Reset.
REQ-044 Scenario 8: InstrCount preloaded by 65535 Turbo Go cycles -> next Go wraps it to 0.
